addsub_serial: RTL
==================

ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; accepted only in IDLE.
REQ-005 op  input  1  0 = add (A+B), 1 = subtract (A-B); sampled with start.
REQ-006 A, B  input  WIDTH  two's-complement operands; sampled with start.
REQ-007 D  output  WIDTH  registered result.
REQ-008 Overflow, Negative, Zero, Carry  output  1 each  registered flags.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse marking a new valid D/flags.

Function
REQ-011 FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after WIDTH bit steps; DONE->IDLE unconditionally next cycle.
REQ-012 On accept: latch A, B, op internally; clear bit counter; seed carry with op; B operand inverted when op=1.
REQ-013 RUN: one full-adder step per cycle, LSB first, into an internal shift register; D and flags SHALL hold their previous values throughout RUN.
REQ-014 On the RUN->DONE edge, D, Overflow, Negative, Zero, Carry SHALL update together.
REQ-015 done SHALL be high exactly in the cycle beginning WIDTH rising edges after the edge that sampled start; total latency WIDTH cycles, throughput one operation per WIDTH+2 cycles.
REQ-016 start in RUN or DONE SHALL be ignored (no latch, no queuing); A/B/op changes during RUN SHALL not affect the result.
REQ-017 D = (A op B) mod 2^WIDTH (unsaturated build).
REQ-018 Overflow = signed overflow: operands (B inverted for subtract) of equal sign, raw-result sign differs.
REQ-019 Negative = sign of the mathematically exact result = raw MSB XOR Overflow.
REQ-020 Zero = 1 iff D is all zeros (after any saturation).
REQ-021 Carry = carry-out of the MSB step (for subtract: 1 = no borrow, A >= B unsigned).

Reset
REQ-022 rst=1 at any edge, including mid-RUN or in DONE: state->IDLE; D, all flags, busy, done -> 0; in-flight operation discarded, no done issued.
REQ-023 start coincident with rst SHALL be ignored.

Configuration
REQ-024 Macro ADDSUB_SERIAL_SAT_EN defined: on Overflow=1, D SHALL clamp to max positive (0111..1) if Negative=0, else min negative (1000..0); Overflow still reports 1.
REQ-025 Macro undefined: D wraps per REQ-017; no saturation logic present.

Structure
REQ-026 Package addsub_serial_pkg SHALL hold the state enum (IDLE, RUN, DONE) and op encodings (OP_ADD=0, OP_SUB=1).
REQ-027 One sub-module fa_1bit (combinational full adder: a, b, cin -> s, cout) SHALL be instantiated for the bit step.

Verification
REQ-028 WIDTH=8, op=1, A=8'h05, B=8'h07 -> done 8 cycles after start edge; D=8'hFE, N=1, Z=0, V=0, C=0.
REQ-029 WIDTH=8, op=1, A=8'h80, B=8'h01 -> V=1, N=1, C=1; D=8'h7F, or 8'h80 with ADDSUB_SERIAL_SAT_EN.
REQ-030 WIDTH=8, op=0, A=8'h7F, B=8'h01 -> V=1, N=0; D=8'h80, or 8'h7F with ADDSUB_SERIAL_SAT_EN; op=1, A=B=8'h3C -> D=0, Z=1, C=1.
REQ-031 Start, then rst high on the 3rd RUN cycle -> next cycle busy=0, all outputs 0, done never pulses; new start afterwards completes normally.
REQ-032 Second start pulsed during RUN with different operands -> ignored; only first result reported; busy stays high through DONE.
REQ-033 WIDTH=4 exhaustive sweep, both ops, all 256 A/B pairs -> D and all four flags match a signed reference model on every done pulse, both macro settings.

Source files
------------

// File: rtl/addsub_serial_pkg.sv
// Shared types for the bit-serial add/subtract unit: FSM state encoding and op codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package addsub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_serial_fa_1bit.sv
// One-bit full adder used as the per-cycle bit step of the serial adder.
// Latency: purely combinational.
// Backpressure: none.
module fa_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_serial.sv
// Bit-serial two's-complement add/subtract, LSB first, one full-adder step per cycle.
// Latency: done pulses WIDTH cycles after the accepting edge; one op per WIDTH+2 cycles.
// Backpressure: start is honoured only in IDLE; starts while busy are dropped, not queued.
// Optional build macro ADDSUB_SERIAL_SAT_EN clamps D on signed overflow.
module addsub_serial
    import addsub_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             Overflow,
    output logic             Negative,
    output logic             Zero,
    output logic             Carry,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;     // A, shifted right one bit per step
    logic [WIDTH-1:0] b_sh;     // B (already inverted for subtract), shifted likewise
    logic [WIDTH-1:0] res;      // sum bits enter at the top and walk down
    logic             cy;       // carry into the current bit step
    logic [CW-1:0]    cnt;      // index of the bit being added

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] res_shift;
    logic             v_next;
    logic             n_next;
    logic [WIDTH-1:0] d_next;

    fa_1bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (cy),
        .s    (s_bit),
        .cout (c_bit)
    );

    // Next accumulator value and, on the final step, the complete result and flags.
    always_comb begin
        res_shift = {s_bit, {(WIDTH-1){1'b0}}} | (res >> 1);
        // On the last step a_sh[0]/b_sh[0] are the operand sign bits and s_bit the raw sign.
        v_next    = (a_sh[0] == b_sh[0]) && (s_bit != a_sh[0]);
        n_next    = s_bit ^ v_next;
        d_next    = res_shift;
`ifdef ADDSUB_SERIAL_SAT_EN
        if (v_next) begin
            d_next = n_next ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Control FSM plus serial datapath; outputs only change on reset or the RUN->DONE edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            cy       <= 1'b0;
            cnt      <= '0;
            D        <= '0;
            Overflow <= 1'b0;
            Negative <= 1'b0;
            Zero     <= 1'b0;
            Carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= (op == OP_SUB) ? ~B : B;
                        cy    <= (op == OP_SUB);  // +1 completes the two's-complement negate
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cy   <= c_bit;
                    res  <= res_shift;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        D        <= d_next;
                        Overflow <= v_next;
                        Negative <= n_next;
                        Zero     <= (d_next == '0);
                        Carry    <= c_bit;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
